// File: rtl/m_axi_stream_pkg.sv
// Shared constants and state type for the AXI4-Stream egress stage.
package m_axi_stream_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int LWIDTH_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/m_axi_stream_queue.sv
// Two-entry register FIFO that feeds an AXI4-Stream output.
// The head is always held in slot0, so it can drive tdata directly.
module axis_out_queue #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         xrst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q != 2'd2) begin
          if (cnt_q == 2'd0) slot0_d = data_i;
          else               slot1_d = data_i;
          cnt_d = cnt_q + 2'd1;
        end
      end
      2'b01: begin
        if (cnt_q != 2'd0) begin
          slot0_d = slot1_q;
          cnt_d   = cnt_q - 2'd1;
        end
      end
      2'b11: begin
        // Push and pop together leave the count unchanged.
        if (cnt_q == 2'd2) begin
          slot0_d = slot1_q;
          slot1_d = data_i;
        end else begin
          slot0_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (xrst_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign head_o  = slot0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/m_axi_stream.sv
// AXI4-Stream master egress: drains the output buffer in commanded bursts.
// A 2-entry queue hides the 1-cycle buffer read latency and tready backpressure.
module m_axi_stream
  import m_axi_stream_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int LWIDTH = LWIDTH_DEF
) (
  input  logic                clk,
  input  logic                xrst,
  input  logic                start,
  input  logic [LWIDTH-1:0]   len,
  output logic                busy,
  output logic                done,
  input  logic                buf_isempty,
  output logic                buf_re,
  input  logic [DWIDTH-1:0]   buf_rdata,
  output logic                tvalid,
  output logic [DWIDTH-1:0]   tdata,
  output logic [DWIDTH/8-1:0] tstrb,
  output logic                tlast,
  input  logic                tready
);

  state_e            state_q, state_d;
  logic [LWIDTH-1:0] len_q, len_d;
  logic [LWIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [LWIDTH-1:0] bt_cnt_q, bt_cnt_d;
  logic              inflight_q;
  logic              pop;
  logic [1:0]        q_cnt;
  logic [DWIDTH-1:0] q_head;
  logic [2:0]        occ;

  axis_out_queue #(.W(DWIDTH)) u_queue (
    .clk_i   (clk),
    .xrst_i  (xrst),
    .push_i  (inflight_q),
    .data_i  (buf_rdata),
    .pop_i   (pop),
    .head_o  (q_head),
    .count_o (q_cnt)
  );

  assign pop    = tvalid && tready;
  assign tvalid = (q_cnt != 2'd0);
  assign tdata  = tvalid ? q_head : '0;
  assign tstrb  = tvalid ? '1 : '0;
  assign tlast  = tvalid && (bt_cnt_q == len_q - LWIDTH'(1));
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

  // Occupancy the queue will have once this cycle's pop and the pending read settle.
  always_comb begin
    occ = {1'b0, q_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  end

  assign buf_re = (state_q == S_STREAM) && (rd_cnt_q < len_q) &&
                  !buf_isempty && (occ < 3'd2);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q + LWIDTH'(buf_re);
    bt_cnt_d = bt_cnt_q + LWIDTH'(pop);
    case (state_q)
      S_IDLE: begin
        if (start && (len != '0)) begin
          len_d    = len;
          rd_cnt_d = '0;
          bt_cnt_d = '0;
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        if (pop && tlast) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      bt_cnt_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      bt_cnt_q   <= bt_cnt_d;
      inflight_q <= buf_re;
    end
  end

endmodule
